// File: rtl/spi_slave.sv
// SPI mode-0 target with a memory-mapped data/status register pair on the CPU bus.
// Define SPI_SLAVE_RXFIFO_EN to replace the single RX byte register with a 4-entry RX FIFO.
module spi_slave #(
  parameter logic [31:0] ADDR = 32'hffff_ffff
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        spi_ready,
  output logic        spi_sel,
  output logic [31:0] spi_rdata
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned SYNC_W  = 3;
  localparam logic [BYTE_W-1:0] FILL_BYTE = 8'hFF;

  // Pin synchronisers; stage [1] is the synchronised value, stage [2] the edge reference
  logic [SYNC_W-1:0] r_sck_sync;
  logic [SYNC_W-1:0] r_cs_sync;
  logic [1:0]        r_mosi_sync;
  logic [SYNC_W-1:0] r_init;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_init      <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_W-2:0], spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_W-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
      r_init      <= {r_init[SYNC_W-2:0], 1'b1};
    end
  end

  // Edges are ignored until the pipeline holds real pin values, so a CS held low
  // across reset release is not mistaken for a fresh CS fall.
  logic w_edges_en;
  logic w_cs_active;
  logic w_cs_fall;
  logic w_cs_rise;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_mosi;

  assign w_edges_en  = r_init[SYNC_W-1];
  assign w_cs_active = ~r_cs_sync[1];
  assign w_cs_fall   = w_edges_en & ~r_cs_sync[1] &  r_cs_sync[2];
  assign w_cs_rise   = w_edges_en &  r_cs_sync[1] & ~r_cs_sync[2];
  assign w_sck_rise  = w_edges_en &  r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall  = w_edges_en & ~r_sck_sync[1] &  r_sck_sync[2];
  assign w_mosi      = r_mosi_sync[1];

  // Bus decode
  logic w_hit_data;
  logic w_hit_stat;
  logic w_is_wr;
  logic w_data_rd;
  logic w_data_wr;
  logic w_stat_wr;
  logic w_ovr_clr;
  logic w_unused;

  assign w_hit_data = (mem_addr == ADDR);
  assign w_hit_stat = (mem_addr == (ADDR + 32'd4));
  assign w_is_wr    = |mem_wstrb;
  assign spi_sel    = mem_valid & (w_hit_data | w_hit_stat);
  assign w_data_rd  = spi_sel & w_hit_data & ~w_is_wr;
  assign w_stat_wr  = spi_sel & w_hit_stat & w_is_wr;
  assign w_ovr_clr  = w_stat_wr & mem_wstrb[0] & mem_wdata[2];
  assign w_unused   = ^mem_wdata[31:8];

  logic r_tx_full;
  assign w_data_wr = spi_sel & w_hit_data & w_is_wr & ~r_tx_full;
  assign spi_ready = spi_sel & ~(w_hit_data & w_is_wr & r_tx_full);

  // Bit counter, RX shifter and TX shifter
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [BYTE_W-1:0] r_rx_shift;
  logic [BYTE_W-1:0] r_tx_shift;
  logic [BYTE_W-1:0] r_tx_hold;
  logic              w_tx_load;
  logic              w_byte_done;
  logic [BYTE_W-1:0] w_rx_byte;

  assign w_tx_load   = w_cs_fall | (w_cs_active & w_sck_fall & (r_bit_cnt == '0));
  assign w_byte_done = ~w_cs_fall & w_cs_active & w_sck_rise & (r_bit_cnt == CNT_W'(7));
  assign w_rx_byte   = {r_rx_shift[BYTE_W-2:0], w_mosi};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= FILL_BYTE;
    end else begin
      if (w_cs_fall || w_cs_rise) begin
        r_bit_cnt <= '0;
      end else if (w_cs_active && w_sck_rise) begin
        r_rx_shift <= w_rx_byte;
        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
      end
      if (w_tx_load) begin
        r_tx_shift <= r_tx_full ? r_tx_hold : FILL_BYTE;
      end else if (w_cs_active && w_sck_fall) begin
        r_tx_shift <= {r_tx_shift[BYTE_W-2:0], 1'b1};
      end
    end
  end

  // TX holding register; a write can only land while it is empty
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx_hold <= '0;
      r_tx_full <= 1'b0;
    end else begin
      if (w_tx_load && r_tx_full) begin
        r_tx_full <= 1'b0;
      end
      if (w_data_wr && mem_wstrb[0]) begin
        r_tx_hold <= mem_wdata[BYTE_W-1:0];
        r_tx_full <= 1'b1;
      end
    end
  end

  logic              r_overrun;
  logic              w_rx_valid;
  logic [BYTE_W-1:0] w_rd_byte;

`ifdef SPI_SLAVE_RXFIFO_EN
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned OCC_W      = 3;

  logic [BYTE_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_count;
  logic [BYTE_W-1:0] r_rx_data;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == OCC_W'(FIFO_DEPTH));
  assign w_pop      = w_data_rd & ~w_empty;
  assign w_push     = w_byte_done & (~w_full | w_pop);
  assign w_rx_valid = ~w_empty;
  assign w_rd_byte  = w_empty ? r_rx_data : r_fifo[r_rd_ptr];

  // RX FIFO; r_rx_data remembers the last popped byte for reads of an empty FIFO
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rx_data <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rx_data <= r_fifo[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_rx_byte;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      r_count <= r_count + OCC_W'(w_push) - OCC_W'(w_pop);
      if (w_ovr_clr) begin
        r_overrun <= 1'b0;
      end
      if (w_byte_done && !w_push) begin
        r_overrun <= 1'b1;
      end
    end
  end
`else
  logic [BYTE_W-1:0] r_rx_data;
  logic              r_rx_valid;

  assign w_rx_valid = r_rx_valid;
  assign w_rd_byte  = r_rx_data;

  // Single RX byte; a read in the completing cycle frees the slot for the new byte
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_data_rd) begin
        r_rx_valid <= 1'b0;
      end
      if (w_ovr_clr) begin
        r_overrun <= 1'b0;
      end
      if (w_byte_done) begin
        if (!r_rx_valid || w_data_rd) begin
          r_rx_data  <= w_rx_byte;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end
`endif

  assign spi_miso    = r_tx_shift[BYTE_W-1];
  assign spi_miso_oe = w_cs_active;

  // Read data mux
  always_comb begin
    spi_rdata = '0;
    if (spi_sel && !w_is_wr) begin
      if (w_hit_data) begin
        spi_rdata = {24'h0, w_rd_byte};
      end else begin
        spi_rdata = {27'h0, w_cs_active, 1'b0, r_overrun, ~r_tx_full, w_rx_valid};
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: randomized SPI master + bus traffic against a
// queue-based reference model of the TX holding byte, RX buffer and overrun flag.
module tb_spi_slave;

  localparam logic [31:0] BASE = 32'h0300_0010;
  localparam logic [31:0] DATA = BASE;
  localparam logic [31:0] STAT = BASE + 32'd4;
`ifdef SPI_SLAVE_RXFIFO_EN
  localparam int RX_CAP = 4;
`else
  localparam int RX_CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        spi_ready;
  logic        spi_sel;
  logic [31:0] spi_rdata;

  spi_slave #(.ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .spi_ready(spi_ready), .spi_sel(spi_sel), .spi_rdata(spi_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [7:0] m_rxq[$];
  logic [7:0] m_last;
  logic       m_ovr;
  logic       m_hold_full;
  logic [7:0] m_hold;
  logic [7:0] m_cur;

  task automatic m_reset();
    m_rxq.delete();
    m_last = 8'h00; m_ovr = 1'b0; m_hold_full = 1'b0; m_hold = 8'h00; m_cur = 8'hFF;
  endtask

  function automatic logic [7:0] m_next_tx();
    if (m_hold_full) begin
      m_hold_full = 1'b0;
      return m_hold;
    end
    return 8'hFF;
  endfunction

  function automatic void m_rx_push(input logic [7:0] b);
    if (m_rxq.size() < RX_CAP) m_rxq.push_back(b);
    else m_ovr = 1'b1;
  endfunction

  function automatic logic [7:0] m_read();
    if (m_rxq.size() > 0) m_last = m_rxq.pop_front();
    return m_last;
  endfunction

  function automatic logic [31:0] m_status();
    return {27'h0, 1'b0, 1'b0, m_ovr, ~m_hold_full, 1'(m_rxq.size() != 0)};
  endfunction

  // Bus and SPI drivers
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic rdy);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wstrb = 4'b0000; mem_wdata = '0;
    #1;
    rdy = spi_ready;
    d   = spi_rdata;
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_addr = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input int budget,
                           output int waited, output bit ok);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = 4'b0001;
    waited = 0; ok = 1'b0;
    while (!ok && waited < budget) begin
      #1;
      if (spi_ready === 1'b1) ok = 1'b1;
      else begin
        waited++;
        @(negedge clk);
      end
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    mem_valid = 1'b0; mem_wstrb = '0; mem_addr = '0;
  endtask

  task automatic spi_begin();
    @(negedge clk);
    spi_cs_n = 1'b0;
    m_cur = m_next_tx();
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (6) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Clocks nbits MSB-first; rd_last issues a data read in the cycle the 8th bit completes
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit rd_last,
                          output logic [7:0] miso_got, output logic [7:0] miso_exp,
                          output logic [31:0] rd_got, output logic [7:0] rd_exp);
    logic rdy;
    miso_got = 8'h00; rd_got = '0; rd_exp = 8'h00;
    miso_exp = m_cur;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      repeat (6) @(negedge clk);
      miso_got[7-i] = spi_miso;
      spi_sck = 1'b1;
      if (rd_last && i == 7) begin
        @(negedge clk);
        bus_read(DATA, rd_got, rdy);
        repeat (3) @(negedge clk);
      end else begin
        repeat (6) @(negedge clk);
      end
      spi_sck = 1'b0;
    end
    if (nbits == 8) begin
      if (rd_last) rd_exp = m_read();
      m_rx_push(tx);
      m_cur = m_next_tx();
    end
  endtask

  logic [31:0] d;
  logic        r;
  logic [7:0]  mg, me, rde;
  logic [31:0] rdg;
  int          waited;
  bit          ok;

  task automatic test_reset();
    resetn = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (spi_miso !== 1'b1 || spi_miso_oe !== 1'b0) begin
      n_fail++; $display("FAIL reset_pins: miso=%b oe=%b expected miso=1 oe=0", spi_miso, spi_miso_oe);
    end
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (spi_ready !== 1'b0 || spi_sel !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_bus: ready=%b sel=%b expected 0 0", spi_ready, spi_sel);
    end
    bus_read(STAT, d, r);
    n_tests++;
    if (d !== 32'h2 || r !== 1'b1) begin
      n_fail++; $display("FAIL reset_status: got %h ready=%b expected 00000002 ready=1", d, r);
    end
    bus_read(DATA, d, r);
    n_tests++;
    if (d !== 32'h0 || r !== 1'b1) begin
      n_fail++; $display("FAIL reset_data: got %h ready=%b expected 00000000 ready=1", d, r);
    end
    bus_read(BASE + 32'd8, d, r);
    n_tests++;
    if (r !== 1'b0) begin
      n_fail++; $display("FAIL unmapped_ready: got %b expected 0", r);
    end
  endtask

  task automatic test_tx_rx_basic();
    bus_write(DATA, 32'hA5, 50, waited, ok);
    m_hold = 8'hA5; m_hold_full = 1'b1;
    n_tests++;
    if (!ok || waited != 0) begin
      n_fail++; $display("FAIL basic_write: ok=%0d waited=%0d expected ok=1 waited=0", ok, waited);
    end
    spi_begin();
    n_tests++;
    if (spi_miso_oe !== 1'b1) begin
      n_fail++; $display("FAIL basic_oe: got %b expected 1", spi_miso_oe);
    end
    spi_xfer(8'h3C, 8, 1'b0, mg, me, rdg, rde);
    n_tests++;
    if (mg !== me || me !== 8'hA5) begin
      n_fail++; $display("FAIL basic_miso: got %h expected %h", mg, me);
    end
    spi_end();
    bus_read(STAT, d, r);
    n_tests++;
    if (d !== m_status()) begin
      n_fail++; $display("FAIL basic_status: got %h expected %h", d, m_status());
    end
    bus_read(DATA, d, r);
    rde = m_read();
    n_tests++;
    if (d !== {24'h0, rde} || rde !== 8'h3C) begin
      n_fail++; $display("FAIL basic_data: got %h expected %h", d, {24'h0, rde});
    end
    bus_read(STAT, d, r);
    n_tests++;
    if (d !== m_status()) begin
      n_fail++; $display("FAIL basic_status_after: got %h expected %h", d, m_status());
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = m_rxq.size();
    for (int i = 0; i < n; i++) begin
      bus_read(DATA, d, r);
      rde = m_read();
      n_tests++;
      if (d !== {24'h0, rde}) begin
        n_fail++; $display("FAIL %s_drain%0d: got %h expected %h", name, i, d, {24'h0, rde});
      end
    end
  endtask

  task automatic test_fill_overrun();
    spi_begin();
    for (int i = 0; i < 2; i++) begin
      spi_xfer(8'($urandom), 8, 1'b0, mg, me, rdg, rde);
      n_tests++;
      if (mg !== me || me !== 8'hFF) begin
        n_fail++; $display("FAIL fill_miso%0d: got %h expected %h", i, mg, me);
      end
    end
    spi_end();
    bus_read(STAT, d, r);
    n_tests++;
    if (d !== m_status()) begin
      n_fail++; $display("FAIL overrun_status: got %h expected %h", d, m_status());
    end
    bus_write(STAT, 32'h4, 10, waited, ok);
    m_ovr = 1'b0;
    bus_read(STAT, d, r);
    n_tests++;
    if (d !== m_status() || !ok) begin
      n_fail++; $display("FAIL overrun_clear: got %h ok=%0d expected %h ok=1", d, ok, m_status());
    end
    drain("fill");
  endtask

  task automatic test_stall();
    bus_write(DATA, 32'h22, 10, waited, ok);
    m_hold = 8'h22; m_hold_full = 1'b1;
    fork
      bus_write(DATA, 32'h11, 200, waited, ok);
      begin
        repeat (20) @(negedge clk);
        spi_begin();
      end
    join
    m_hold = 8'h11; m_hold_full = 1'b1;
    n_tests++;
    if (!ok || waited < 19) begin
      n_fail++; $display("FAIL stall_write: ok=%0d waited=%0d expected ok=1 waited>=19", ok, waited);
    end
    spi_xfer(8'($urandom), 8, 1'b0, mg, me, rdg, rde);
    n_tests++;
    if (mg !== me || me !== 8'h22) begin
      n_fail++; $display("FAIL stall_miso: got %h expected %h", mg, me);
    end
    spi_end();
    bus_read(STAT, d, r);
    n_tests++;
    if (d !== m_status()) begin
      n_fail++; $display("FAIL stall_status: got %h expected %h", d, m_status());
    end
    drain("stall");
  endtask

  task automatic test_partial();
    spi_begin();
    spi_xfer(8'($urandom), 5, 1'b0, mg, me, rdg, rde);
    spi_end();
    spi_begin();
    spi_xfer(8'h81, 8, 1'b0, mg, me, rdg, rde);
    n_tests++;
    if (mg !== me) begin
      n_fail++; $display("FAIL partial_miso: got %h expected %h", mg, me);
    end
    spi_end();
    bus_read(STAT, d, r);
    n_tests++;
    if (d !== m_status()) begin
      n_fail++; $display("FAIL partial_status: got %h expected %h", d, m_status());
    end
    bus_read(DATA, d, r);
    rde = m_read();
    n_tests++;
    if (d !== {24'h0, rde} || rde !== 8'h81) begin
      n_fail++; $display("FAIL partial_data: got %h expected %h", d, {24'h0, rde});
    end
    bus_read(STAT, d, r);
    n_tests++;
    if (d !== m_status()) begin
      n_fail++; $display("FAIL partial_once: got %h expected %h", d, m_status());
    end
  endtask

  task automatic test_coincident();
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    spi_begin();
    spi_xfer(b1, 8, 1'b0, mg, me, rdg, rde);
    spi_xfer(b2, 8, 1'b1, mg, me, rdg, rde);
    n_tests++;
    if (rdg !== {24'h0, rde}) begin
      n_fail++; $display("FAIL coincident_read: got %h expected %h", rdg, {24'h0, rde});
    end
    spi_end();
    bus_read(STAT, d, r);
    n_tests++;
    if (d !== m_status()) begin
      n_fail++; $display("FAIL coincident_status: got %h expected %h", d, m_status());
    end
    drain("coinc");
  endtask

  task automatic test_fifo_fill();
    spi_begin();
    for (int i = 1; i <= 5; i++) begin
      spi_xfer(8'(i), 8, 1'b0, mg, me, rdg, rde);
    end
    spi_end();
    bus_read(STAT, d, r);
    n_tests++;
    if (d !== m_status()) begin
      n_fail++; $display("FAIL fifo_status: got %h expected %h", d, m_status());
    end
    for (int i = 0; i < 5; i++) begin
      bus_read(DATA, d, r);
      rde = m_read();
      n_tests++;
      if (d !== {24'h0, rde}) begin
        n_fail++; $display("FAIL fifo_read%0d: got %h expected %h", i, d, {24'h0, rde});
      end
    end
    bus_write(STAT, 32'h4, 10, waited, ok);
    m_ovr = 1'b0;
  endtask

  task automatic test_random();
    int nb, nr;
    for (int s = 0; s < 6; s++) begin
      if (!m_hold_full && $urandom_range(0, 1) == 1) begin
        m_hold = 8'($urandom);
        bus_write(DATA, {24'h0, m_hold}, 10, waited, ok);
        m_hold_full = 1'b1;
      end
      spi_begin();
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        spi_xfer(8'($urandom), 8, 1'b0, mg, me, rdg, rde);
        n_tests++;
        if (mg !== me) begin
          n_fail++; $display("FAIL rand_miso_s%0d_b%0d: got %h expected %h", s, b, mg, me);
        end
      end
      spi_end();
      bus_read(STAT, d, r);
      n_tests++;
      if (d !== m_status()) begin
        n_fail++; $display("FAIL rand_status_s%0d: got %h expected %h", s, d, m_status());
      end
      nr = $urandom_range(0, 2);
      for (int k = 0; k < nr; k++) begin
        bus_read(DATA, d, r);
        rde = m_read();
        n_tests++;
        if (d !== {24'h0, rde}) begin
          n_fail++; $display("FAIL rand_data_s%0d_%0d: got %h expected %h", s, k, d, {24'h0, rde});
        end
      end
      if (m_ovr) begin
        bus_write(STAT, 32'h4, 10, waited, ok);
        m_ovr = 1'b0;
      end
    end
    drain("rand");
  endtask

  task automatic test_reset_mid();
    bus_write(DATA, 32'h77, 10, waited, ok);
    m_hold = 8'h77; m_hold_full = 1'b1;
    spi_begin();
    spi_xfer(8'($urandom), 3, 1'b0, mg, me, rdg, rde);
    @(negedge clk);
    resetn = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    spi_xfer(8'h5A, 8, 1'b0, mg, me, rdg, rde);
    n_tests++;
    if (mg !== me || me !== 8'hFF) begin
      n_fail++; $display("FAIL resetmid_miso: got %h expected %h", mg, me);
    end
    spi_end();
    bus_read(DATA, d, r);
    rde = m_read();
    n_tests++;
    if (d !== {24'h0, rde} || rde !== 8'h5A) begin
      n_fail++; $display("FAIL resetmid_data: got %h expected %h", d, {24'h0, rde});
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_rx_basic();
    test_fill_overrun();
    test_stall();
    test_partial();
    test_coincident();
    test_fifo_fill();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
